goalie_motion_ctrl: RTL and testbench
=====================================

// Module: goalie_motion_ctrl
// PURPOSE
//  Sequences the goalie stepper. Homes on the limit switch, then moves to absolute step targets.
//  Targets come from two requesters: CPU commands written via reg_24, and automatic phototransistor
//  requests (min_address, move_goalie). The CPU has priority. Drives step/dir/enable and returns a
//  status word for reg_25. Sits between the IO register interface and the stepper driver pins.
// PARAMETERS
//  STEP_DIV      50000  clk cycles per step half-period (step high STEP_DIV, low STEP_DIV)
//  DEB_LEN       10     consecutive equal samples needed to change debounced limit_switch
//  MAX_POS       400    highest legal position in steps; larger targets clamp to MAX_POS
//  SLOT_STEPS    50     steps per auto slot; auto target = auto_addr*SLOT_STEPS + SLOT_OFFSET
//  SLOT_OFFSET   25     step offset of slot 0 centre
//  BACKOFF       8      steps driven away from the switch after it trips while homing
//  HOME_MAX      1000   homing step budget; exceeding it enters FAULT
// PORTS
//  clk           in   1   system clock (100 MHz)
//  reset         in   1   synchronous, active-high reset
//  cmd_valid     in   1   CPU command present
//  cmd_ready     out  1   command accepted this cycle when cmd_valid && cmd_ready
//  cmd_data      in   32  [15:0] target, [16] home request, [17] auto_en value, [18] clear fault
//  auto_valid    in   1   phototransistor move request (move_goalie), level
//  auto_addr     in   3   requested slot (min_address)
//  limit_switch  in   1   raw limit switch, high = pressed (at position 0)
//  step          out  1   step pulse to driver
//  dir           out  1   1 = increasing position, 0 = toward switch
//  motor_en      out  1   driver enable
//  status        out  32  {position[15:0], 8'd0, fault, limit_hit, auto_en, homed, busy, state[2:0]}
// BEHAVIOUR
//  Reset values: step=0, dir=0, motor_en=0, cmd_ready=0, position=0, homed=0, auto_en=0,
//   fault=0, limit_hit=0, state=HOME. Debounce history = 0. Reset mid-move aborts immediately.
//  States: HOME=0, BACKOFF=1, IDLE=2, MOVE=3, FAULT=4.
//  HOME: motor_en=1, dir=0. Step until the debounced switch is 1. Then set position=0 and go to
//   BACKOFF. If HOME_MAX steps complete without the switch, go to FAULT.
//  BACKOFF: dir=1, BACKOFF steps. Then position=BACKOFF, homed=1, go to IDLE.
//  IDLE: cmd_ready=1 only here and in FAULT. Accepted command:
//   home bit -> homed=0, HOME. Otherwise the target is clamped; target==position stays in IDLE.
//   In all cases auto_en <= cmd_data[17].
//   With no CPU command: auto_valid && auto_en && homed -> target from auto_addr (clamped).
//   Same-cycle CPU and auto: CPU wins; the auto request is ignored (it is a level, so resampled).
//  MOVE: dir = (target > position). Step timing: step rises at period start, falls after
//   STEP_DIV cycles. position +/-1 on the cycle step falls (2*STEP_DIV cycles per step).
//   Returns to IDLE on the cycle position==target. First step rises 1 cycle after acceptance.
//   Debounced switch=1 while dir=0: stop at once, position=0, limit_hit=1 (sticky), IDLE.
//   Commands and auto requests are not accepted during MOVE; the target is never changed.
//  FAULT: motor_en=0, step=0. Only a command with bit18=1 is accepted; it clears fault and
//   limit_hit, homed=0, next state HOME. Other commands are accepted and dropped.
//  busy = state is HOME, BACKOFF or MOVE. status is registered (1-cycle latency to state).
//  Position arithmetic: 16-bit unsigned. Clamping prevents wrap above MAX_POS.
//   Underflow is impossible: a move toward 0 ends at target>=0 or at the switch.
//  Step counter: ceil(log2(2*STEP_DIV)) bits, reloaded on every state entry.
// STRUCTURE
//  Shared package (io_pkg): state encodings, cmd_data bit indices, status field layout.
//  Sub-module: limit_debounce (DEB_LEN shift register, changes output only on a unanimous window).
//  Step timing counter, position register and FSM are inline.
// TESTING (STEP_DIV=2, DEB_LEN=3, BACKOFF=2, HOME_MAX=20)
//  1 Switch raised after 5 steps in HOME -> BACKOFF 2 steps with dir=1; IDLE, position=2, homed=1.
//  2 Switch never raised -> FAULT after 20 steps, motor_en=0. Cmd bit18=1 -> HOME, fault=0.
//  3 IDLE pos=2, cmd target=10 -> 8 steps, dir=1, 4 clk per step; IDLE at position=10.
//    Cmd target=999 -> clamps to 400.
//  4 auto_en=1, auto_valid=1 addr=3 and cmd target=0 in same cycle -> moves to 0 (CPU wins).
//    Next IDLE: auto -> moves to 175.
//  5 Moving 10->0, switch pressed at position 6 -> stop after debounce, position=0, limit_hit=1, IDLE.
//  6 reset asserted mid-MOVE -> next cycle every output is at its reset value, state=HOME.

Source files
------------

// File: rtl/goalie_motion_ctrl_pkg.sv
// goalie_motion_ctrl_pkg
//   Shared definitions for the goalie stepper controller: FSM state
//   encodings, cmd_data bit positions, status word layout and small helpers
//   for target clamping and status packing.
//   No ports (package).

package goalie_motion_ctrl_pkg;

  // State encodings are visible to software through status[2:0].
  typedef enum logic [2:0] {
    ST_HOME    = 3'd0,
    ST_BACKOFF = 3'd1,
    ST_IDLE    = 3'd2,
    ST_MOVE    = 3'd3,
    ST_FAULT   = 3'd4
  } motion_state_t;

  // cmd_data field positions
  localparam int CMD_TARGET_MSB  = 15;
  localparam int CMD_HOME_BIT    = 16;
  localparam int CMD_AUTO_EN_BIT = 17;
  localparam int CMD_CLEAR_BIT   = 18;

  // status word field positions
  localparam int STS_STATE_LSB   = 0;
  localparam int STS_BUSY_BIT    = 3;
  localparam int STS_HOMED_BIT   = 4;
  localparam int STS_AUTO_EN_BIT = 5;
  localparam int STS_LIMIT_BIT   = 6;
  localparam int STS_FAULT_BIT   = 7;
  localparam int STS_POS_LSB     = 16;

  // Saturate a requested position to the highest legal step so that the
  // 16-bit position register can never be driven past the end of travel.
  function automatic logic [15:0] clamp_pos(input logic [31:0] raw,
                                            input logic [15:0] max_pos);
    if (raw > {16'd0, max_pos}) begin
      return max_pos;
    end
    return raw[15:0];
  endfunction

  function automatic logic [31:0] pack_status(input logic [15:0]     position,
                                              input logic            fault,
                                              input logic            limit_hit,
                                              input logic            auto_en,
                                              input logic            homed,
                                              input logic            busy,
                                              input motion_state_t   state);
    logic [31:0] word;
    word = 32'd0;
    word[STS_POS_LSB +: 16]   = position;
    word[STS_FAULT_BIT]       = fault;
    word[STS_LIMIT_BIT]       = limit_hit;
    word[STS_AUTO_EN_BIT]     = auto_en;
    word[STS_HOMED_BIT]       = homed;
    word[STS_BUSY_BIT]        = busy;
    word[STS_STATE_LSB +: 3]  = state;
    return word;
  endfunction

endpackage

// File: rtl/goalie_motion_ctrl_limit_debounce.sv
// limit_debounce
//   Filters the raw limit switch. The last DEB_LEN samples are kept in a
//   shift register and the clean output only changes when the whole window
//   agrees, so a bouncing contact never toggles the output.
// Ports
//   clk    in   system clock
//   reset  in   synchronous active-high reset (history and output to 0)
//   raw    in   raw switch level, high = pressed
//   clean  out  debounced switch level

module limit_debounce #(
  parameter int DEB_LEN = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  logic [DEB_LEN-1:0] history;

  always_ff @(posedge clk) begin
    if (reset) begin
      history <= '0;
      clean   <= 1'b0;
    end else begin
      history <= {history[DEB_LEN-2:0], raw};
      if (&history) begin
        clean <= 1'b1;
      end else if (~|history) begin
        clean <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/goalie_motion_ctrl.sv
// goalie_motion_ctrl
//   Sequences the goalie stepper: homes against the limit switch, backs off,
//   then moves to absolute step targets requested either by the CPU (reg_24
//   writes, priority) or by the phototransistor logic (slot requests).
// Ports
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   cmd_valid     in   CPU command present
//   cmd_ready     out  command accepted when cmd_valid && cmd_ready
//   cmd_data      in   [15:0] target, [16] home, [17] auto_en, [18] clear fault
//   auto_valid    in   automatic move request (level)
//   auto_addr     in   requested slot
//   limit_switch  in   raw limit switch, high = pressed at position 0
//   step          out  step pulse to driver
//   dir           out  1 = increasing position
//   motor_en      out  driver enable
//   status        out  {position, 8'd0, fault, limit_hit, auto_en, homed, busy, state}

module goalie_motion_ctrl #(
  parameter int STEP_DIV    = 50000,
  parameter int DEB_LEN     = 10,
  parameter int MAX_POS     = 400,
  parameter int SLOT_STEPS  = 50,
  parameter int SLOT_OFFSET = 25,
  parameter int BACKOFF     = 8,
  parameter int HOME_MAX    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        auto_valid,
  input  logic [2:0]  auto_addr,
  input  logic        limit_switch,
  output logic        step,
  output logic        dir,
  output logic        motor_en,
  output logic [31:0] status
);

  import goalie_motion_ctrl_pkg::*;

  localparam int CNT_W  = $clog2(2 * STEP_DIV);
  localparam int HOME_W = $clog2(HOME_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_FALL   = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(2 * STEP_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HIGH   = CNT_W'(STEP_DIV);
  localparam logic [HOME_W-1:0] HOME_LAST  = HOME_W'(HOME_MAX - 1);
  localparam logic [15:0]       MAX_POS_V  = 16'(MAX_POS);
  localparam logic [15:0]       BACKOFF_V  = 16'(BACKOFF);

  motion_state_t     state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [HOME_W-1:0] home_cnt, home_cnt_next;
  logic [15:0]       position, position_next;
  logic [15:0]       target, target_next;
  logic              homed, homed_next;
  logic              auto_en, auto_en_next;
  logic              fault, fault_next;
  logic              limit_hit, limit_hit_next;
  logic              step_next, dir_next, motor_en_next;

  logic              switch_clean;
  logic              stepping;
  logic              step_tick;
  logic              move_up;
  logic              busy;
  logic [15:0]       cmd_target;
  logic [15:0]       auto_target;
  logic [15:0]       position_inc;
  logic [15:0]       position_dec;
  logic [15:0]       position_step;
  logic              unused_cmd_bits;

  limit_debounce #(
    .DEB_LEN (DEB_LEN)
  ) u_limit_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (limit_switch),
    .clean (switch_clean)
  );

  assign unused_cmd_bits = ^cmd_data[31:19];

  assign stepping  = (state == ST_HOME) || (state == ST_BACKOFF) || (state == ST_MOVE);
  assign busy      = stepping;
  // A step completes on the edge where the pulse falls; that is where the
  // position and the homing budget advance.
  assign step_tick = stepping && (cnt == CNT_FALL);
  assign move_up   = target > position;
  assign cmd_ready = (state == ST_IDLE) || (state == ST_FAULT);

  assign cmd_target   = clamp_pos({16'd0, cmd_data[CMD_TARGET_MSB:0]}, MAX_POS_V);
  assign auto_target  = clamp_pos(32'(auto_addr) * 32'(SLOT_STEPS) + 32'(SLOT_OFFSET),
                                  MAX_POS_V);
  assign position_inc = position + 16'd1;
  assign position_dec = position - 16'd1;
  assign position_step = move_up ? position_inc : position_dec;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    home_cnt_next  = home_cnt;
    position_next  = position;
    target_next    = target;
    homed_next     = homed;
    auto_en_next   = auto_en;
    fault_next     = fault;
    limit_hit_next = limit_hit;

    case (state)
      ST_HOME: begin
        if (switch_clean) begin
          position_next = 16'd0;
          state_next    = ST_BACKOFF;
        end else if (step_tick) begin
          if (home_cnt == HOME_LAST) begin
            fault_next = 1'b1;
            state_next = ST_FAULT;
          end else begin
            home_cnt_next = home_cnt + 1'b1;
          end
        end
      end

      // Position starts at 0 on entry, so it doubles as the back-off count.
      ST_BACKOFF: begin
        if (step_tick) begin
          position_next = position_inc;
          if (position_inc == BACKOFF_V) begin
            homed_next = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      // The CPU is checked first; an auto request seen in the same cycle is
      // simply not acted on and will be seen again since it is a level.
      ST_IDLE: begin
        if (cmd_valid) begin
          auto_en_next = cmd_data[CMD_AUTO_EN_BIT];
          if (cmd_data[CMD_HOME_BIT]) begin
            homed_next = 1'b0;
            state_next = ST_HOME;
          end else if (cmd_target != position) begin
            target_next = cmd_target;
            state_next  = ST_MOVE;
          end
        end else if (auto_valid && auto_en && homed && (auto_target != position)) begin
          target_next = auto_target;
          state_next  = ST_MOVE;
        end
      end

      // Hitting the switch while heading toward it means the position has
      // drifted; trust the switch and resynchronise to 0.
      ST_MOVE: begin
        if (switch_clean && !move_up) begin
          position_next  = 16'd0;
          limit_hit_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (step_tick) begin
          position_next = position_step;
          if (position_step == target) begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_FAULT: begin
        if (cmd_valid && cmd_data[CMD_CLEAR_BIT]) begin
          fault_next     = 1'b0;
          limit_hit_next = 1'b0;
          homed_next     = 1'b0;
          state_next     = ST_HOME;
        end
      end

      default: begin
        state_next = ST_HOME;
      end
    endcase

    // Every state entry restarts the step period and the homing budget.
    if (state_next != state) begin
      cnt_next      = '0;
      home_cnt_next = '0;
    end else if (stepping) begin
      cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Pin values are derived from the next-cycle state so they are registered
  // yet line up with the state they belong to.
  always_comb begin
    step_next     = 1'b0;
    dir_next      = 1'b0;
    motor_en_next = (state_next != ST_FAULT);
    case (state_next)
      ST_HOME: begin
        step_next = (cnt_next < CNT_HIGH);
      end
      ST_BACKOFF: begin
        step_next = (cnt_next < CNT_HIGH);
        dir_next  = 1'b1;
      end
      ST_MOVE: begin
        step_next = (cnt_next < CNT_HIGH);
        dir_next  = (target_next > position_next);
      end
      default: begin
        step_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HOME;
      cnt       <= '0;
      home_cnt  <= '0;
      position  <= 16'd0;
      target    <= 16'd0;
      homed     <= 1'b0;
      auto_en   <= 1'b0;
      fault     <= 1'b0;
      limit_hit <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      motor_en  <= 1'b0;
      status    <= 32'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      home_cnt  <= home_cnt_next;
      position  <= position_next;
      target    <= target_next;
      homed     <= homed_next;
      auto_en   <= auto_en_next;
      fault     <= fault_next;
      limit_hit <= limit_hit_next;
      step      <= step_next;
      dir       <= dir_next;
      motor_en  <= motor_en_next;
      status    <= pack_status(position, fault, limit_hit, auto_en, homed, busy, state);
    end
  end

endmodule

// File: tb/tb_goalie_motion_ctrl.sv
// tb_goalie_motion_ctrl
//   Directed bench for goalie_motion_ctrl with short timing parameters
//   (STEP_DIV=2, DEB_LEN=3, BACKOFF=2, HOME_MAX=20). Inputs change and
//   outputs are sampled on the falling clock edge.

module tb_goalie_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        auto_valid;
  logic [2:0]  auto_addr;
  logic        limit_switch;
  logic        step;
  logic        dir;
  logic        motor_en;
  logic [31:0] status;

  int total_checks = 0;
  int pass_checks  = 0;
  int fail_checks  = 0;
  int step_rises   = 0;
  logic step_prev;
  int base;

  goalie_motion_ctrl #(
    .STEP_DIV    (2),
    .DEB_LEN     (3),
    .MAX_POS     (400),
    .SLOT_STEPS  (50),
    .SLOT_OFFSET (25),
    .BACKOFF     (2),
    .HOME_MAX    (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .auto_valid   (auto_valid),
    .auto_addr    (auto_addr),
    .limit_switch (limit_switch),
    .step         (step),
    .dir          (dir),
    .motor_en     (motor_en),
    .status       (status)
  );

  always #5 clk = ~clk;

  // Counts rising edges of the step pin.
  always @(negedge clk) begin
    step_prev <= step;
    if (step === 1'b1 && step_prev === 1'b0) begin
      step_rises <= step_rises + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) pass_checks++;
    else begin
      fail_checks++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic with_auto,
                                input logic [2:0] addr);
    cmd_valid  = 1'b1;
    cmd_data   = data;
    auto_valid = with_auto;
    auto_addr  = addr;
    tick(1);
    cmd_valid  = 1'b0;
    cmd_data   = 32'd0;
    auto_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (status[2:0] !== st && n < budget) begin
      tick(1);
      n++;
    end
    check_output(tag, {29'd0, status[2:0]}, {29'd0, st});
  endtask

  task automatic wait_position(input string tag, input logic [15:0] pos, input int budget);
    int n = 0;
    while (status[31:16] !== pos && n < budget) begin
      tick(1);
      n++;
    end
    check_output(tag, {16'd0, status[31:16]}, {16'd0, pos});
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = 32'd0;
    auto_valid   = 1'b0;
    auto_addr    = 3'd0;
    limit_switch = 1'b0;
    tick(3);
    check_output("reset_step",      {31'd0, step},      32'd0);
    check_output("reset_dir",       {31'd0, dir},       32'd0);
    check_output("reset_motor_en",  {31'd0, motor_en},  32'd0);
    check_output("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check_output("reset_status",    status,             32'd0);

    // Homing with the switch never pressed runs out of budget.
    base  = step_rises;
    reset = 1'b0;
    wait_state("fault_entry", 3'd4, 300);
    check_output("fault_home_steps", step_rises - base, 32'd20);
    check_output("fault_motor_en",   {31'd0, motor_en},  32'd0);
    check_output("fault_step",       {31'd0, step},      32'd0);
    check_output("fault_bit",        {31'd0, status[7]}, 32'd1);
    check_output("fault_busy",       {31'd0, status[3]}, 32'd0);
    check_output("fault_cmd_ready",  {31'd0, cmd_ready}, 32'd1);

    apply_stimulus(32'h0000_000A, 1'b0, 3'd0);
    tick(2);
    check_output("fault_drop_cmd", {29'd0, status[2:0]}, 32'd4);

    apply_stimulus(32'h0004_0000, 1'b0, 3'd0);
    tick(2);
    check_output("clear_state_home", {29'd0, status[2:0]}, 32'd0);
    check_output("clear_fault_bit",  {31'd0, status[7]},   32'd0);
    check_output("home_motor_en",    {31'd0, motor_en},    32'd1);
    check_output("home_dir",         {31'd0, dir},         32'd0);

    // Homing: switch pressed after five steps.
    base = step_rises;
    begin
      int n = 0;
      while (step_rises - base < 5 && n < 100) begin
        tick(1);
        n++;
      end
    end
    check_output("home_five_steps", {31'd0, step_rises - base >= 5}, 32'd1);
    limit_switch = 1'b1;
    wait_state("backoff_entry", 3'd1, 40);
    check_output("backoff_dir", {31'd0, dir}, 32'd1);
    limit_switch = 1'b0;
    wait_state("homed_idle", 3'd2, 40);
    check_output("homed_position",  {16'd0, status[31:16]}, 32'd2);
    check_output("homed_bit",       {31'd0, status[4]},     32'd1);
    check_output("idle_cmd_ready",  {31'd0, cmd_ready},     32'd1);

    // Move 2 -> 10: eight steps of four clocks each.
    base = step_rises;
    apply_stimulus(32'h0000_000A, 1'b0, 3'd0);
    check_output("move_first_step", {31'd0, step}, 32'd1);
    check_output("move_up_dir",     {31'd0, dir},  32'd1);
    tick(30);
    check_output("move_last_cycle", {29'd0, status[2:0]}, 32'd3);
    tick(1);
    check_output("move_done_state", {29'd0, status[2:0]},   32'd2);
    check_output("move_done_pos",   {16'd0, status[31:16]}, 32'd10);
    check_output("move_step_count", step_rises - base,      32'd8);

    // Oversized target clamps to the end of travel.
    apply_stimulus(32'd999, 1'b0, 3'd0);
    tick(2);
    check_output("clamp_moving", {29'd0, status[2:0]}, 32'd3);
    wait_state("clamp_idle", 3'd2, 2000);
    check_output("clamp_pos", {16'd0, status[31:16]}, 32'd400);

    // Enable auto mode with a no-op command, then race CPU against auto.
    apply_stimulus(32'h0002_0190, 1'b0, 3'd0);
    tick(2);
    check_output("noop_stays_idle", {29'd0, status[2:0]}, 32'd2);
    check_output("auto_en_set",     {31'd0, status[5]},   32'd1);
    apply_stimulus(32'h0002_0000, 1'b1, 3'd3);
    check_output("cpu_wins_dir", {31'd0, dir}, 32'd0);
    tick(2);
    wait_state("cpu_wins_idle", 3'd2, 2000);
    check_output("cpu_wins_pos", {16'd0, status[31:16]}, 32'd0);

    auto_valid = 1'b1;
    auto_addr  = 3'd3;
    tick(2);
    check_output("auto_moving", {29'd0, status[2:0]}, 32'd3);
    auto_valid = 1'b0;
    check_output("auto_dir", {31'd0, dir}, 32'd1);
    wait_state("auto_idle", 3'd2, 1000);
    check_output("auto_pos", {16'd0, status[31:16]}, 32'd175);

    // Move toward the switch and press it part way down.
    apply_stimulus(32'h0000_000A, 1'b0, 3'd0);
    tick(2);
    wait_state("pre_limit_idle", 3'd2, 1000);
    check_output("pre_limit_pos", {16'd0, status[31:16]}, 32'd10);
    apply_stimulus(32'h0000_0000, 1'b0, 3'd0);
    wait_position("limit_at_six", 16'd6, 100);
    limit_switch = 1'b1;
    wait_state("limit_idle", 3'd2, 14);
    check_output("limit_pos", {16'd0, status[31:16]}, 32'd0);
    check_output("limit_hit", {31'd0, status[6]},     32'd1);
    check_output("limit_dir", {31'd0, dir},           32'd0);
    limit_switch = 1'b0;
    tick(6);

    // Reset in the middle of a move.
    apply_stimulus(32'h0000_0064, 1'b0, 3'd0);
    check_output("pre_reset_step", {31'd0, step}, 32'd1);
    reset = 1'b1;
    tick(1);
    check_output("midreset_step",      {31'd0, step},      32'd0);
    check_output("midreset_dir",       {31'd0, dir},       32'd0);
    check_output("midreset_motor_en",  {31'd0, motor_en},  32'd0);
    check_output("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check_output("midreset_status",    status,             32'd0);
    reset = 1'b0;
    tick(2);
    check_output("post_reset_state", {29'd0, status[2:0]}, 32'd0);
    check_output("post_reset_busy",  {31'd0, status[3]},   32'd1);
    check_output("post_reset_en",    {31'd0, motor_en},    32'd1);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
